// File: rtl/main_memory_responder.sv
// Backing main memory for the cache controller: accepts one request at a time and
// answers with an aligned BLOCK_WORDS-word burst or a single-word write after LATENCY cycles.
module main_memory_responder #(
  parameter int WORD_LEN    = 32,
  parameter int ADDRESS_LEN = 15,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           req_write,
  input  logic [ADDRESS_LEN-1:0]         req_addr,
  input  logic [WORD_LEN-1:0]            wr_data,
  output logic                           busy,
  output logic                           rd_valid,
  output logic [WORD_LEN-1:0]            rd_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] rd_word_idx,
  output logic                           done,
  output logic [ADDRESS_LEN-1:0]         fetch_counter
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << ADDRESS_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_WR_ACK
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_wait_cnt;
  logic                     r_is_write;
  logic [ADDRESS_LEN-1:0]   r_addr;
  logic [WORD_LEN-1:0]      r_wdata;
  logic                     r_busy;
  logic                     r_rd_valid;
  logic [WORD_LEN-1:0]      r_rd_data;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_done;
  logic [ADDRESS_LEN-1:0]   r_fetch_cnt;

  // Each word is stored XOR-ed with its own address, so an all-zero power-up
  // array reads back as mem[i] = i without any initialisation sweep.
  logic [WORD_LEN-1:0]      r_mem [DEPTH];

  logic [IDX_W-1:0]         w_burst_idx;
  logic [ADDRESS_LEN-1:0]   w_rd_addr;
  logic [WORD_LEN-1:0]      w_rd_word;
  logic                     w_wait_done;
  logic                     w_commit;

  // Word 0 is fetched on the WAIT->BURST edge, later words on each BURST edge.
  assign w_burst_idx = (r_state == S_BURST) ? r_idx + IDX_W'(1) : '0;
  assign w_rd_addr   = {r_addr[ADDRESS_LEN-1:IDX_W], w_burst_idx};
  assign w_rd_word   = r_mem[w_rd_addr] ^ WORD_LEN'(w_rd_addr);
  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(1));
  assign w_commit    = w_wait_done && r_is_write && !rst;

  // NOTE: the storage array has no reset on purpose; clearing 32K words is not
  // possible in one cycle and reset must leave memory contents untouched.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_addr] <= r_wdata ^ WORD_LEN'(r_addr);
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_is_write <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= wr_data;
            r_busy     <= 1'b1;
            r_wait_cnt <= CNT_W'(LATENCY);
            r_state    <= S_WAIT;
            if (!req_write) begin
              r_fetch_cnt <= r_fetch_cnt + ADDRESS_LEN'(1);
            end
          end
        end

        S_WAIT: begin
          if (w_wait_done) begin
            if (r_is_write) begin
              r_done  <= 1'b1;
              r_state <= S_WR_ACK;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_rd_word;
              r_idx      <= '0;
              r_state    <= S_BURST;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end

        S_BURST: begin
          if (r_idx == LAST_IDX) begin
            // rd_data and rd_word_idx deliberately keep the last burst word.
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_idx     <= w_burst_idx;
            r_rd_data <= w_rd_word;
            r_done    <= (w_burst_idx == LAST_IDX);
          end
        end

        S_WR_ACK: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rd_word_idx   = r_idx;
  assign done          = r_done;
  assign fetch_counter = r_fetch_cnt;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level timing/memory model.
module tb_main_memory_responder;

  localparam int WL  = 32;
  localparam int AL  = 15;
  localparam int BW  = 4;
  localparam int LAT = 4;
  localparam int IW  = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          req_write;
  logic [AL-1:0] req_addr;
  logic [WL-1:0] wr_data;
  logic          busy;
  logic          rd_valid;
  logic [WL-1:0] rd_data;
  logic [IW-1:0] rd_word_idx;
  logic          done;
  logic [AL-1:0] fetch_counter;

  main_memory_responder #(
    .WORD_LEN(WL), .ADDRESS_LEN(AL), .BLOCK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .wr_data(wr_data), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_word_idx(rd_word_idx), .done(done), .fetch_counter(fetch_counter)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is "m_j edges old"; outputs follow from the
  // request-to-response timing rules, memory is a plain word array.
  logic [WL-1:0] m_mem [1 << AL];
  int            m_j = -1;
  bit            m_wr;
  logic [AL-1:0] m_addr;
  logic [WL-1:0] m_wdata;
  logic          exp_busy = 0, exp_valid = 0, exp_done = 0;
  logic [WL-1:0] exp_data = 0;
  logic [IW-1:0] exp_idx = 0;
  logic [AL-1:0] exp_fetch = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_j = -1;
      exp_busy = 0; exp_valid = 0; exp_done = 0;
      exp_data = 0; exp_idx = 0; exp_fetch = 0;
    end else if (m_j < 0) begin
      exp_busy = 0; exp_valid = 0; exp_done = 0;
      if (req) begin
        m_j = 0; m_wr = req_write; m_addr = req_addr; m_wdata = wr_data;
        exp_busy = 1;
        if (!req_write) exp_fetch = exp_fetch + 1'b1;
      end
    end else begin
      int end_j;
      m_j++;
      end_j = m_wr ? LAT + 1 : LAT + BW;
      if (m_j == end_j) begin
        m_j = -1;
        exp_busy = 0; exp_valid = 0; exp_done = 0;
      end else if (m_wr) begin
        exp_busy = 1; exp_valid = 0;
        exp_done = (m_j == LAT);
        if (m_j == LAT) m_mem[m_addr] = m_wdata;
      end else begin
        exp_busy = 1;
        exp_valid = (m_j >= LAT);
        exp_done = (m_j == LAT + BW - 1);
        if (exp_valid) begin
          int k;
          k = m_j - LAT;
          exp_idx = IW'(k);
          exp_data = m_mem[(int'(m_addr) / BW) * BW + k];
        end
      end
    end
  end

  bit            mon_en = 0;
  logic [WL-1:0] got_q[$];
  logic [IW-1:0] idx_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", busy, exp_busy);
      check("rd_valid", rd_valid, exp_valid);
      check("done", done, exp_done);
      check("rd_data", rd_data, exp_data);
      check("rd_word_idx", rd_word_idx, exp_idx);
      check("fetch_counter", fetch_counter, exp_fetch);
      if (rd_valid) begin
        got_q.push_back(rd_data);
        idx_q.push_back(rd_word_idx);
      end
    end
  end

  // Issue one request from an idle point and return once the model is idle again.
  task automatic send(input bit w, input logic [AL-1:0] a, input logic [WL-1:0] d);
    req = 1; req_write = w; req_addr = a; wr_data = d;
    @(negedge clk);
    req = 0;
    while (m_j >= 0) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AL); i++) m_mem[i] = WL'(i);
    rst = 1; req = 0; req_write = 0; req_addr = '0; wr_data = '0;

    // 1: reset state, then initial contents of word 5
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_fetch", fetch_counter, 0);
    rst = 0;
    mon_en = 1;
    got_q.delete();
    send(0, 15'd5, '0);
    check("init_mem5", got_q[1], 32'd5);

    // 2: read of 1026 returns the aligned block 1024..1027
    pulse_reset();
    got_q.delete(); idx_q.delete();
    send(0, 15'd1026, '0);
    check("t2_len", got_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_data%0d", k), got_q[k], 32'd1024 + k);
      check($sformatf("t2_idx%0d", k), idx_q[k], k);
    end
    check("t2_fetch", fetch_counter, 1);

    // 3: unaligned write, then read its block back
    send(1, 15'd1025, 32'hDEADBEEF);
    check("t3_fetch", fetch_counter, 1);
    got_q.delete();
    send(0, 15'd1024, '0);
    check("t3_w0", got_q[0], 32'd1024);
    check("t3_w1", got_q[1], 32'hDEADBEEF);
    check("t3_w2", got_q[2], 32'd1026);
    check("t3_w3", got_q[3], 32'd1027);

    // 4: req held high; address change while busy is not sampled
    pulse_reset();
    got_q.delete();
    req = 1; req_write = 0; req_addr = 15'd0;
    @(negedge clk);
    req_addr = 15'd4;
    repeat (LAT + BW) @(negedge clk);
    check("t4_busy_gap", busy, 0);
    @(negedge clk);
    req = 0;
    check("t4_second_accept", busy, 1);
    while (m_j >= 0) @(negedge clk);
    check("t4_len", got_q.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("t4_data%0d", k), got_q[k], k);
    check("t4_fetch", fetch_counter, 2);

    // 5: reset in the middle of a burst and in the middle of a write wait
    req = 1; req_write = 0; req_addr = 15'd200;
    @(negedge clk);
    req = 0;
    repeat (5) @(negedge clk);
    pulse_reset();
    check("t5_busy", busy, 0);
    check("t5_rd_valid", rd_valid, 0);
    check("t5_done", done, 0);
    check("t5_fetch", fetch_counter, 0);
    req = 1; req_write = 1; req_addr = 15'd2000; wr_data = 32'h12345678;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    pulse_reset();
    got_q.delete();
    send(0, 15'd2000, '0);
    check("t5_wr_discarded", got_q[0], 32'd2000);

    // 6: top block, no wrap past the end of the address space
    got_q.delete(); idx_q.delete();
    send(0, 15'h7FFE, '0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_data%0d", k), got_q[k], 32'h7FFC + k);
      check($sformatf("t6_idx%0d", k), idx_q[k], k);
    end

    // random traffic: requests at any time (ignored while busy), rare resets
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req       = ($urandom_range(0, 2) == 0);
      req_write = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) req_addr = AL'(15'h7FF8 + $urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 0) req_addr = AL'($urandom_range(0, 63));
      else req_addr = AL'($urandom_range(0, (1 << AL) - 1));
      wr_data = $urandom;
      @(negedge clk);
    end
    rst = 0; req = 0;
    while (m_j >= 0) @(negedge clk);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
